cache_nway: RTL and testbench
=============================

Name: cache_nway

Overview:
- Parametrised N-way set-associative write-back, write-allocate cache for the MP datapath.
- Sits between the CPU word port (mem_*) and the physical-memory line port (pmem_*).
- Generalises the earlier fixed-geometry cache in ways, sets and line size.
- Adds deterministic replacement and a whole-cache flush.

Parameters:
NUM_WAYS, 2, ways per set (power of 2, >=2)
NUM_SETS, 8, sets (power of 2, >=2)
LINE_WORDS, 8, 32-bit words per line (power of 2, >=2); line width LB = 32*LINE_WORDS

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_address  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_read  in  1  read request, held until mem_resp
mem_write  in  1  write request, held until mem_resp
mem_byte_enable  in  4  byte lanes for writes
mem_rdata  out  32  read data, valid when mem_resp
mem_resp  out  1  one-cycle completion pulse
pmem_rdata  in  LB  fill line
pmem_resp  in  1  physical memory done
pmem_address  out  32  line-aligned address
pmem_wdata  out  LB  writeback line
pmem_read  out  1  fill request
pmem_write  out  1  writeback request
flush_req  in  1  level request: write back all dirty lines, invalidate all
flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Address split: OB = log2(LINE_WORDS*4) offset bits; IB = log2(NUM_SETS) index bits at [OB+IB-1:OB]; tag = [31:OB+IB]; word select = [OB-1:2].
- Storage is flip-flop arrays with combinational lookup.
- Reset (async, rst_n=0):
  - all valid/dirty bits and per-set round-robin pointers = 0; state = IDLE.
  - all outputs = 0.
  - tag/data contents unspecified.
- Reset mid-operation: pmem_read/pmem_write drop in the same cycle; the request is abandoned.
- IDLE:
  - If mem_read|mem_write is high and the request hits: mem_resp=1 in the same cycle.
  - Read hit: mem_rdata = selected word.
  - Write hit: bytes with mem_byte_enable set are merged at the clock edge; dirty is set.
  - Both mem_read and mem_write high: treated as a write.
  - Miss: latch the victim way. If the victim is valid and dirty, go to WRITEBACK, else go to FILL.
  - If there is no mem request and flush_req=1, go to FLUSH_SCAN with set/way counter = 0. A mem request always takes priority over flush.
- Victim selection: lowest-index invalid way. If all ways are valid, use the set's RR pointer; the pointer increments (wrapping) only on fills that used it.
- WRITEBACK:
  - pmem_write=1; pmem_address = {victim tag, index, OB zeros}; pmem_wdata = victim line.
  - Outputs are held stable until pmem_resp. On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1; pmem_address = {req tag, index, OB zeros}, held stable.
  - On pmem_resp: write line and tag, valid=1, dirty=0, then go to IDLE.
  - The held request hits on the next cycle.
- Latency:
  - hit = 0 extra cycles.
  - clean miss = fill wait + 2 cycles.
  - dirty miss adds the writeback wait + 1 cycle.
- FLUSH_SCAN:
  - Visits (set, way) in order: set-major, way-minor, one entry per cycle.
  - A dirty entry goes to FLUSH_WB, which behaves like WRITEBACK for that entry; on pmem_resp, clear dirty and return to FLUSH_SCAN.
  - After the last entry: clear all valid bits and RR pointers, pulse flush_done for 1 cycle, go to IDLE.
  - flush_req is ignored while a flush is in progress. Still high in IDLE afterwards means a new flush.
- mem_resp and flush_done are never high outside the cases above. pmem_read and pmem_write are never high together.

Test Plan:
- Reset, read 0x0000_0040:
  - Required: pmem_read with pmem_address=0x40; no pmem_write.
  - Return a line with word0=0xDEADBEEF; next cycle mem_resp=1 with mem_rdata=0xDEADBEEF.
- Hit merge: word1 of line 0x40 = 0xAABBCCDD; write 0x44, data 0x11223344, byte_enable 0011.
  - Required: mem_resp in the same cycle.
  - A read of 0x44 then returns 0xAABB3344; no pmem traffic throughout.
- Conflict eviction in set 2 (default geometry): access 0x040 (left dirty by the previous scenario), then 0x140, then 0x240.
  - Required: the third access picks way0 (RR=0) and issues pmem_write @0x040 with word1=0xAABB3344.
  - Then pmem_read @0x240; the RR pointer of set 2 becomes 1.
- Stall: delay pmem_resp 5 cycles on a fill.
  - Required: pmem_read, pmem_address and mem_resp=0 stay stable for all 5 cycles; exactly one mem_resp follows.
- Flush with exactly one dirty line (set 3) plus clean lines:
  - Required: exactly one pmem_write, then one flush_done pulse.
  - A subsequent read of any previously cached address misses.
- Async reset mid-fill: drive rst_n=0 while pmem_read=1.
  - Required: pmem_read=0 and mem_resp=0 immediately.
  - After release, a re-read of the same address misses.

Source files
------------

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate cache with flip-flop storage,
// per-set round-robin replacement and a whole-cache flush.
module cache_nway #(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 8,
  localparam int LB        = 32*LINE_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   mem_address,
  input  logic [31:0]   mem_wdata,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    mem_byte_enable,
  output logic [31:0]   mem_rdata,
  output logic          mem_resp,
  input  logic [LB-1:0] pmem_rdata,
  input  logic          pmem_resp,
  output logic [31:0]   pmem_address,
  output logic [LB-1:0] pmem_wdata,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic          flush_req,
  output logic          flush_done
);
  localparam int OB = $clog2(LINE_WORDS*4);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 32 - OB - IB;
  localparam int WB = $clog2(NUM_WAYS);
  localparam int SB = $clog2(LINE_WORDS);
  localparam int CB = IB + WB;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FSCAN, S_FWB} state_t;
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  state_t state, state_n;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid, dirty;
  logic [NUM_SETS-1:0][WB-1:0]       rr;
  logic [TB-1:0] tags [NUM_SETS][NUM_WAYS];
  line_t         data [NUM_SETS][NUM_WAYS];

  logic [TB-1:0] tag, r_tag;
  logic [IB-1:0] idx, r_idx, fl_idx, wb_idx;
  logic [SB-1:0] wsel;
  logic [WB-1:0] hit_way, vic_way, v_way, fl_way, wb_way;
  logic [CB-1:0] fl_cnt;
  logic          hit, vic_rr, v_rr, req, wr_hit, fill_done, fl_last;
  logic [31:0]   wmask, merged;
  logic          unused_addr;

  assign tag         = mem_address[31:OB+IB];
  assign idx         = mem_address[OB+IB-1:OB];
  assign wsel        = mem_address[OB-1:2];
  assign unused_addr = ^mem_address[1:0];
  assign req         = mem_read | mem_write;
  assign fl_idx      = fl_cnt[CB-1:WB];
  assign fl_way      = fl_cnt[WB-1:0];
  assign fl_last     = (fl_cnt == {CB{1'b1}});
  assign wb_idx      = (state == S_FWB) ? fl_idx : r_idx;
  assign wb_way      = (state == S_FWB) ? fl_way : v_way;
  assign wr_hit      = (state == S_IDLE) && mem_write && hit;
  assign fill_done   = (state == S_FILL) && pmem_resp;
  assign wmask       = {{8{mem_byte_enable[3]}}, {8{mem_byte_enable[2]}},
                        {8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
  assign merged      = (data[idx][hit_way][wsel] & ~wmask) | (mem_wdata & wmask);

  // Descending scan so the lowest-index matching/invalid way is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = rr[idx];
    vic_rr  = 1'b1;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WB'(w);
      end
      if (!valid[idx][w]) begin
        vic_way = WB'(w);
        vic_rr  = 1'b0;
      end
    end
  end

  always_comb begin
    state_n      = state;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    flush_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (!mem_write) mem_rdata = data[idx][hit_way][wsel];
          end else begin
            state_n = (valid[idx][vic_way] && dirty[idx][vic_way]) ? S_WB : S_FILL;
          end
        end else if (flush_req) begin
          state_n = S_FSCAN;
        end
      end
      S_WB, S_FWB: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[wb_idx][wb_way], wb_idx, {OB{1'b0}}};
        pmem_wdata   = data[wb_idx][wb_way];
        if (pmem_resp) state_n = (state == S_WB) ? S_FILL : S_FSCAN;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_tag, r_idx, {OB{1'b0}}};
        if (pmem_resp) state_n = S_IDLE;
      end
      S_FSCAN: begin
        if (dirty[fl_idx][fl_way]) begin
          state_n = S_FWB;
        end else if (fl_last) begin
          flush_done = 1'b1;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      valid  <= '0;
      dirty  <= '0;
      rr     <= '0;
      fl_cnt <= '0;
      v_way  <= '0;
      v_rr   <= 1'b0;
      r_tag  <= '0;
      r_idx  <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (wr_hit) begin
            dirty[idx][hit_way] <= 1'b1;
          end else if (req && !hit) begin
            v_way <= vic_way;
            v_rr  <= vic_rr;
            r_tag <= tag;
            r_idx <= idx;
          end else if (!req && flush_req) begin
            fl_cnt <= '0;
          end
        end
        S_FILL: if (pmem_resp) begin
          valid[r_idx][v_way] <= 1'b1;
          dirty[r_idx][v_way] <= 1'b0;
          if (v_rr) rr[r_idx] <= rr[r_idx] + WB'(1);
        end
        S_FSCAN: if (!dirty[fl_idx][fl_way]) begin
          if (fl_last) begin
            valid <= '0;
            rr    <= '0;
          end else begin
            fl_cnt <= fl_cnt + CB'(1);
          end
        end
        S_FWB: if (pmem_resp) dirty[fl_idx][fl_way] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_hit) data[idx][hit_way][wsel] <= merged;
    if (fill_done) begin
      data[r_idx][v_way] <= pmem_rdata;
      tags[r_idx][v_way] <= r_tag;
    end
  end
endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a set/way/memory model predicts pmem traffic,
// read data and latency; one negedge process checks the DUT and acts as pmem.
module tb_cache_nway;
  localparam int W = 2, S = 8, LW = 8, LB = 32*LW, OB = 5, IB = 3;

  logic          clk = 0, rst_n = 0;
  logic [31:0]   mem_address = '0, mem_wdata = '0, mem_rdata, pmem_address;
  logic          mem_read = 0, mem_write = 0, mem_resp, pmem_resp = 0;
  logic [3:0]    mem_byte_enable = '0;
  logic [LB-1:0] pmem_rdata = '0, pmem_wdata;
  logic          pmem_read, pmem_write, flush_req = 0, flush_done;

  cache_nway #(.NUM_WAYS(W), .NUM_SETS(S), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .flush_req(flush_req),
    .flush_done(flush_done));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [LB-1:0] line; } wb_t;
  wb_t         wb_q[$];
  logic [31:0] fill_q[$];
  logic [LB-1:0] mem [logic [31:0]];

  // model state
  bit            m_valid [S][W];
  bit            m_dirty [S][W];
  logic [31:0]   m_tag   [S][W];
  logic [LB-1:0] m_data  [S][W];
  int            m_rr    [S];

  int vec = 0, miss = 0;
  bit active = 0, flush_active = 0, in_rst = 1, exp_is_rd = 0;
  int pm_delay = 0, wait_cnt = 0, cyc = 0, resp_cnt = 0, resp_cyc = 0, done_cnt = 0;
  int wb_cnt = 0, fill_cnt = 0, exp_lat = 0;
  logic [31:0]   exp_rdata = '0, last_rdata = '0, last_wb_addr = '0, last_fill_addr = '0;
  logic [LB-1:0] last_wb_line = '0;

  function automatic void chk(string nm, logic [LB-1:0] act, logic [LB-1:0] exp);
    vec++;
    if (act !== exp) begin miss++; $display("FAIL %s: got %h want %h", nm, act, exp); end
  endfunction
  function automatic void chk32(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin miss++; $display("FAIL %s: got %h want %h", nm, act, exp); end
  endfunction
  function automatic void chki(string nm, int act, int exp);
    vec++;
    if (act != exp) begin miss++; $display("FAIL %s: got %0d want %0d", nm, act, exp); end
  endfunction

  function automatic logic [LB-1:0] mem_line(logic [31:0] a);
    logic [LB-1:0] l;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = (a + 32'(i*4)) ^ 32'h5A00_0000;
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < S; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < W; w++) begin m_valid[s][w] = 0; m_dirty[s][w] = 0; end
    end
  endfunction

  // One CPU access at cache level: hit lookup, victim choice, writeback, fill, merge.
  function automatic void model_access(logic [31:0] a, bit wr, logic [31:0] wd, logic [3:0] be);
    int s, wi, h, v;
    bit use_rr;
    logic [31:0] tg, la;
    s = int'(a[OB+IB-1:OB]); wi = int'(a[OB-1:2]); tg = a >> (OB+IB); h = -1;
    for (int w = 0; w < W; w++) if (h < 0 && m_valid[s][w] && m_tag[s][w] == tg) h = w;
    exp_lat = 1;
    if (h < 0) begin
      v = -1;
      for (int w = W-1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      use_rr = (v < 0);
      if (use_rr) v = m_rr[s];
      if (m_valid[s][v] && m_dirty[s][v]) begin
        la = (m_tag[s][v] << (OB+IB)) | 32'(s << OB);
        wb_q.push_back('{la, m_data[s][v]});
        mem[la] = m_data[s][v];
        exp_lat += pm_delay + 1;
      end
      la = (tg << (OB+IB)) | 32'(s << OB);
      fill_q.push_back(la);
      m_data[s][v] = mem_line(la); m_tag[s][v] = tg; m_valid[s][v] = 1; m_dirty[s][v] = 0;
      if (use_rr) m_rr[s] = (m_rr[s] + 1) % W;
      exp_lat += pm_delay + 2;
      h = v;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_data[s][h][wi*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_dirty[s][h] = 1;
    end else begin
      exp_rdata = m_data[s][h][wi*32 +: 32];
    end
  endfunction

  function automatic void model_flush();
    logic [31:0] la;
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          la = (m_tag[s][w] << (OB+IB)) | 32'(s << OB);
          wb_q.push_back('{la, m_data[s][w]});
          mem[la] = m_data[s][w];
          m_dirty[s][w] = 0;
        end
    for (int s = 0; s < S; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < W; w++) m_valid[s][w] = 0;
    end
  endfunction

  // Compare process; also plays physical memory with pm_delay wait cycles.
  initial forever begin
    @(negedge clk);
    pmem_resp = 0;
    if (!in_rst) begin
      if (active || flush_active) cyc++;
      if (pmem_read && pmem_write) chki("pmem_exclusive", 1, 0);
      if (pmem_write) begin
        if (wb_q.size() == 0) chk32("wb_unexpected", pmem_address, 32'hFFFF_FFFF);
        else begin
          chk32("wb_addr", pmem_address, wb_q[0].addr);
          chk("wb_data", pmem_wdata, wb_q[0].line);
          last_wb_addr = pmem_address; last_wb_line = pmem_wdata;
          if (wait_cnt == pm_delay) begin
            pmem_resp = 1; void'(wb_q.pop_front()); wb_cnt++; wait_cnt = 0;
          end else wait_cnt++;
        end
      end else if (pmem_read) begin
        if (fill_q.size() == 0 || wb_q.size() != 0) chk32("fill_unexpected", pmem_address, 32'hFFFF_FFFF);
        else begin
          chk32("fill_addr", pmem_address, fill_q[0]);
          last_fill_addr = pmem_address;
          if (wait_cnt == pm_delay) begin
            pmem_resp = 1; pmem_rdata = mem_line(fill_q[0]);
            void'(fill_q.pop_front()); fill_cnt++; wait_cnt = 0;
          end else wait_cnt++;
        end
      end
      if (mem_resp) begin
        chki("resp_allowed", int'(active && wb_q.size() == 0 && fill_q.size() == 0 && resp_cnt == 0), 1);
        if (exp_is_rd) chk32("rdata", mem_rdata, exp_rdata);
        last_rdata = mem_rdata; resp_cnt++; resp_cyc = cyc;
      end
      if (flush_done) begin
        chki("done_allowed", int'(flush_active && wb_q.size() == 0 && done_cnt == 0), 1);
        done_cnt++;
      end
    end
  end

  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input logic [3:0] be, input int dly);
    int n;
    pm_delay = dly; wait_cnt = 0;
    model_access(a, wr, wd, be);
    exp_is_rd = !wr; resp_cnt = 0; cyc = 0; active = 1;
    mem_address = a; mem_wdata = wd; mem_byte_enable = be; mem_read = rd; mem_write = wr;
    n = 0;
    while (resp_cnt == 0 && n < 300) begin @(posedge clk); #1; n++; end
    mem_read = 0; mem_write = 0; active = 0;
    chki("resp_seen", resp_cnt, 1);
    chki("latency", resp_cyc, exp_lat);
    chki("queues_drained", wb_q.size() + fill_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_flush(input int dly);
    int n;
    pm_delay = dly; wait_cnt = 0; done_cnt = 0;
    model_flush();
    chki("flush_model_dirty_count", wb_q.size(), 1);
    flush_active = 1; flush_req = 1;
    @(posedge clk); #1 flush_req = 0;
    n = 0;
    while (done_cnt == 0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (2) @(posedge clk);
    #1 flush_active = 0;
    chki("flush_done_pulses", done_cnt, 1);
    chki("flush_queue_drained", wb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb0, f0, n;
    logic [LB-1:0] l;
    l = mem_line(32'h40);
    l[31:0] = 32'hDEAD_BEEF; l[63:32] = 32'hAABB_CCDD;
    mem[32'h40] = l;
    model_reset();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chki("rst_mem_resp", int'(mem_resp), 0);
    chk32("rst_mem_rdata", mem_rdata, 0);
    chki("rst_pmem_rw", int'({pmem_read, pmem_write}), 0);
    chk32("rst_pmem_addr", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, '0);
    chki("rst_flush_done", int'(flush_done), 0);
    rst_n = 1; in_rst = 0;
    @(posedge clk); #1;

    access(32'h40, 1, 0, 0, 4'b0000, 0);
    chk32("first_read_word0", last_rdata, 32'hDEAD_BEEF);
    chki("first_read_latency", resp_cyc, 3);

    wb0 = wb_cnt; f0 = fill_cnt;
    access(32'h44, 0, 1, 32'h1122_3344, 4'b0011, 0);
    chki("write_hit_latency", resp_cyc, 1);
    access(32'h44, 1, 0, 0, 4'b0000, 0);
    chk32("merged_word", last_rdata, 32'hAABB_3344);
    chki("hit_no_pmem", wb_cnt + fill_cnt, wb0 + f0);

    access(32'h140, 1, 0, 0, 4'b0000, 1);
    wb0 = wb_cnt;
    access(32'h240, 1, 0, 0, 4'b0000, 1);
    chki("evict_one_wb", wb_cnt, wb0 + 1);
    chk32("evict_wb_addr", last_wb_addr, 32'h40);
    chk32("evict_wb_word1", last_wb_line[63:32], 32'hAABB_3344);
    chk32("evict_fill_addr", last_fill_addr, 32'h240);
    chki("evict_latency", resp_cyc, 6);
    wb0 = wb_cnt;
    access(32'h340, 1, 0, 0, 4'b0000, 0);
    chki("rr_advanced_clean_victim", wb_cnt, wb0);
    chk32("rr_fill_addr", last_fill_addr, 32'h340);

    access(32'h500, 1, 0, 0, 4'b0000, 5);
    chki("stall_latency", resp_cyc, 8);

    access(32'h64, 0, 1, 32'hCAFE_F00D, 4'b1111, 2);
    access(32'h68, 1, 1, 32'h1234_5678, 4'b1100, 0);
    chki("rw_treated_as_write", resp_cyc, 1);
    access(32'h68, 1, 0, 0, 4'b0000, 0);
    chk32("partial_merge", last_rdata, 32'h1234_0068);
    access(32'h64, 1, 0, 0, 4'b0000, 0);
    chk32("write_miss_data", last_rdata, 32'hCAFE_F00D);

    wb0 = wb_cnt;
    do_flush(1);
    chki("flush_one_wb", wb_cnt, wb0 + 1);
    chk32("flush_wb_addr", last_wb_addr, 32'h60);

    access(32'h44, 1, 0, 0, 4'b0000, 0);
    chki("post_flush_miss", resp_cyc, 3);
    chk32("post_flush_data", last_rdata, 32'hAABB_3344);
    access(32'h240, 1, 0, 0, 4'b0000, 0);
    chki("post_flush_miss2", resp_cyc, 3);

    // async reset in the middle of a fill
    pm_delay = 40; wait_cnt = 0; resp_cnt = 0; cyc = 0;
    fill_q.push_back(32'h1000); active = 1; exp_is_rd = 1;
    mem_address = 32'h1000; mem_read = 1;
    n = 0;
    while (!pmem_read && n < 20) begin @(posedge clk); #1; n++; end
    chki("midfill_read_seen", int'(pmem_read), 1);
    @(posedge clk); #2;
    in_rst = 1; rst_n = 0;
    #1;
    chki("midrst_pmem_read", int'(pmem_read), 0);
    chki("midrst_pmem_write", int'(pmem_write), 0);
    chki("midrst_mem_resp", int'(mem_resp), 0);
    mem_read = 0; active = 0;
    fill_q.delete(); wb_q.delete(); model_reset();
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); in_rst = 0;
    @(posedge clk); #1;
    access(32'h1000, 1, 0, 0, 4'b0000, 0);
    chki("post_reset_miss", resp_cyc, 3);
    chk32("post_reset_fill_addr", last_fill_addr, 32'h1000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
